multicycle_ctrl: RTL and testbench

//  Main sequencer for the multi-cycle RV32I datapath; replaces single-cycle decode.
//  - Moore FSM steps each instruction through fetch/decode/execute/memory/writeback.
//  - Drives mux selects, ALU op and write enables, and owns the unified-memory req/ready handshake.
//  - Counts retired instructions; traps on an illegal encoding or a memory timeout.

---
 rtl/multicycle_ctrl_pkg.sv | 66 ++++++
 rtl/multicycle_ctrl_alu_dec.sv | 24 ++
 rtl/multicycle_ctrl.sv | 123 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencer.
// ctrl_for() maps a state to its Moore control word so the top can register it.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_TRAP
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11;
   localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
   localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;
   localparam logic [1:0] RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10;
   localparam logic [1:0] CAUSE_NONE = 2'b00, CAUSE_ILL = 2'b01, CAUSE_TMO = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       adr_src;
      logic       reg_write;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [2:0] alu_ctrl;
      logic [2:0] imm_src;
      logic [1:0] result_src;
   } ctrl_t;

   function automatic ctrl_t ctrl_for(input state_t s, input logic [2:0] alu_op, input logic is_sw);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:    begin c.mem_req = 1'b1; c.src_a = SRCA_PC; c.src_b = SRCB_FOUR;
                           c.alu_ctrl = ALU_ADD; c.result_src = RES_ALU; end
         S_DECODE:   begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_IMM; c.imm_src = IMM_B; end
         S_MEMADR:   begin c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; c.imm_src = is_sw ? IMM_S : IMM_I; end
         S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
         S_MEMWRITE: begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.adr_src = 1'b1; end
         S_MEMWB:    begin c.reg_write = 1'b1; c.result_src = RES_MEM; end
         S_EXECR:    begin c.src_a = SRCA_RS1; c.src_b = SRCB_RS2; c.alu_ctrl = alu_op; end
         S_EXECI:    begin c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; c.imm_src = IMM_I; c.alu_ctrl = alu_op; end
         S_ALUWB:    begin c.reg_write = 1'b1; c.result_src = RES_ALUOUT; end
         S_BRANCH:   begin c.src_a = SRCA_RS1; c.src_b = SRCB_RS2; c.alu_ctrl = ALU_SUB;
                           c.result_src = RES_ALUOUT; end
         S_JAL:      begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_FOUR; c.result_src = RES_ALUOUT; end
         S_LUI:      begin c.src_a = SRCA_ZERO; c.src_b = SRCB_IMM; c.imm_src = IMM_U; end
         default:    c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// funct3 (+ funct7[5] for R-type) to ALU op, with a legality flag for decode.
module multicycle_ctrl_alu_dec
   import multicycle_ctrl_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic       sub_i,
   output logic [2:0] alu_ctrl_o,
   output logic       legal_o
);

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      legal_o    = 1'b1;
      case (funct3_i)
         3'b000:  alu_ctrl_o = sub_i ? ALU_SUB : ALU_ADD;
         3'b111:  alu_ctrl_o = ALU_AND;
         3'b110:  alu_ctrl_o = ALU_OR;
         3'b100:  alu_ctrl_o = ALU_XOR;
         3'b010:  alu_ctrl_o = ALU_SLT;
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multi-cycle RV32I datapath: memory handshake with timeout,
// retired-instruction counter and sticky trap.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [6:0]       opcode_i,
   input  logic [2:0]       funct3_i,
   input  logic [6:0]       funct7_i,
   input  logic             zero_i,
   input  logic             mem_ready_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic             adr_src_o,
   output logic             pc_write_o,
   output logic             ir_write_o,
   output logic             reg_write_o,
   output logic [1:0]       alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [2:0]       alu_ctrl_o,
   output logic [2:0]       imm_src_o,
   output logic [1:0]       result_src_o,
   output logic             trap_o,
   output logic [1:0]       trap_cause_o,
   output logic [CNT_W-1:0] instret_o
);

   localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

   state_t           state_q, state_d;
   ctrl_t            ctrl_q;
   logic             trap_q;
   logic [1:0]       cause_q;
   logic [CNT_W-1:0] instret_q;
   logic [TMO_W-1:0] tmo_q;
   logic [2:0]       alu_op;
   logic             alu_legal, waiting, tmo_hit, retire, br_take;
   logic             unused_funct7;

   assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

   multicycle_ctrl_alu_dec u_alu_dec (
      .funct3_i   (funct3_i),
      .sub_i      ((opcode_i == OP_R) && funct7_i[5]),
      .alu_ctrl_o (alu_op),
      .legal_o    (alu_legal)
   );

   // Counter is zero outside request states, so entering one always starts fresh.
   assign waiting = ctrl_q.mem_req && !mem_ready_i;
   assign tmo_hit = waiting && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode_i)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = alu_legal ? S_EXECR : S_TRAP;
               OP_I:         state_d = alu_legal ? S_EXECI : S_TRAP;
               OP_B:         state_d = (funct3_i[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
               OP_JAL:       state_d = S_JAL;
               OP_LUI:       state_d = S_LUI;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = (opcode_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
         S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
         S_MEMWB, S_ALUWB, S_BRANCH:     state_d = S_FETCH;
         S_EXECR, S_EXECI, S_JAL, S_LUI: state_d = S_ALUWB;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
      if (tmo_hit) state_d = S_TRAP;
   end

   assign retire = (state_d == S_FETCH) &&
                   (state_q inside {S_MEMWRITE, S_MEMWB, S_ALUWB, S_BRANCH});

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_FETCH;
         ctrl_q    <= ctrl_for(S_FETCH, ALU_ADD, 1'b0);
         trap_q    <= 1'b0;
         cause_q   <= CAUSE_NONE;
         instret_q <= '0;
         tmo_q     <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_for(state_d, alu_op, opcode_i == OP_SW);
         tmo_q   <= waiting ? tmo_q + TMO_W'(1) : '0;
         if (retire) instret_q <= instret_q + CNT_W'(1);
         if (state_d == S_TRAP && !trap_q) begin
            trap_q  <= 1'b1;
            cause_q <= tmo_hit ? CAUSE_TMO : CAUSE_ILL;
         end
      end
   end

   assign br_take = ((funct3_i == 3'b000) && zero_i) || ((funct3_i == 3'b001) && !zero_i);

   assign ir_write_o   = (state_q == S_FETCH) && mem_ready_i;
   assign pc_write_o   = ir_write_o || (state_q == S_JAL) || ((state_q == S_BRANCH) && br_take);
   assign mem_req_o    = ctrl_q.mem_req;
   assign mem_we_o     = ctrl_q.mem_we;
   assign adr_src_o    = ctrl_q.adr_src;
   assign reg_write_o  = ctrl_q.reg_write;
   assign alu_src_a_o  = ctrl_q.src_a;
   assign alu_src_b_o  = ctrl_q.src_b;
   assign alu_ctrl_o   = ctrl_q.alu_ctrl;
   assign imm_src_o    = ctrl_q.imm_src;
   assign result_src_o = ctrl_q.result_src;
   assign trap_o       = trap_q;
   assign trap_cause_o = cause_q;
   assign instret_o    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each instruction class stepped cycle by cycle
// against hand-derived control words, plus traps, timeout and mid-instruction reset.
module tb_multicycle_ctrl;

   logic        clk = 1'b0, rst = 1'b1;
   logic [6:0]  opcode = '0, funct7 = '0;
   logic [2:0]  funct3 = '0;
   logic        zero = 1'b0, mem_ready = 1'b0;
   logic        mem_req, mem_we, adr_src, pc_write, ir_write, reg_write, trap;
   logic [1:0]  alu_src_a, alu_src_b, result_src, trap_cause;
   logic [2:0]  alu_ctrl, imm_src;
   logic [31:0] instret;
   int          n_chk = 0, n_err = 0;
   int          exp_ret = 0;

   multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
      .zero_i(zero), .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
      .adr_src_o(adr_src), .pc_write_o(pc_write), .ir_write_o(ir_write),
      .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
      .alu_ctrl_o(alu_ctrl), .imm_src_o(imm_src), .result_src_o(result_src),
      .trap_o(trap), .trap_cause_o(trap_cause), .instret_o(instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Move to the next cycle: inputs change on the falling edge, outputs settle 1ns later.
   task automatic nxt(input logic rdy);
      @(negedge clk);
      mem_ready = rdy;
      #1;
   endtask

   task automatic do_rst();
      rst = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      exp_ret = 0;
   endtask

   // Starts in FETCH, ends positioned in the third cycle of the instruction.
   task automatic fd(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
      opcode = opc; funct3 = f3; funct7 = f7; mem_ready = 1'b1;
      #1;
      chk("F.ir_write", 32'(ir_write), 1);
      chk("F.pc_write", 32'(pc_write), 1);
      chk("F.mem_req",  32'(mem_req), 1);
      chk("F.srcb",     32'(alu_src_b), 2);
      chk("F.result",   32'(result_src), 2);
      nxt(1'b0);
      chk("D.srca",     32'(alu_src_a), 1);
      chk("D.imm",      32'(imm_src), 2);
      chk("D.mem_req",  32'(mem_req), 0);
      nxt(1'b0);
   endtask

   task automatic retire_chk(input string tag);
      exp_ret++;
      chk(tag, instret, 32'(exp_ret));
      chk({tag, ".req"}, 32'(mem_req), 1);
   endtask

   task automatic alu_instr(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [2:0] exp_alu, input logic [1:0] exp_b);
      fd(opc, f3, f7);
      chk({tag, ".alu"},  32'(alu_ctrl), 32'(exp_alu));
      chk({tag, ".srcb"}, 32'(alu_src_b), 32'(exp_b));
      chk({tag, ".srca"}, 32'(alu_src_a), 2);
      nxt(1'b0);
      chk({tag, ".wb"},   32'(reg_write), 1);
      chk({tag, ".res"},  32'(result_src), 0);
      chk({tag, ".pre"},  instret, 32'(exp_ret));
      nxt(1'b0);
      retire_chk({tag, ".ret"});
   endtask

   task automatic branch(input string tag, input logic [2:0] f3, input logic z, input logic exp_pc);
      zero = z;
      fd(7'b1100011, f3, 7'h0);
      chk({tag, ".pcw"}, 32'(pc_write), 32'(exp_pc));
      chk({tag, ".alu"}, 32'(alu_ctrl), 1);
      nxt(1'b0);
      retire_chk({tag, ".ret"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic bad;
      repeat (2) @(posedge clk);
      nxt(1'b0);
      chk("rst.mem_req", 32'(mem_req), 1);
      chk("rst.trap",    32'(trap), 0);
      chk("rst.cause",   32'(trap_cause), 0);
      chk("rst.instret", instret, 0);
      rst = 1'b0;

      alu_instr("add",  7'b0110011, 3'b000, 7'h00, 3'b000, 2'b00);
      alu_instr("sub",  7'b0110011, 3'b000, 7'h20, 3'b001, 2'b00);
      alu_instr("slt",  7'b0110011, 3'b010, 7'h00, 3'b101, 2'b00);
      alu_instr("and",  7'b0110011, 3'b111, 7'h00, 3'b010, 2'b00);
      alu_instr("xori", 7'b0010011, 3'b100, 7'h20, 3'b100, 2'b01);
      alu_instr("ori",  7'b0010011, 3'b110, 7'h00, 3'b011, 2'b01);

      // lw with three wait cycles in MEMREAD
      fd(7'b0000011, 3'b010, 7'h0);
      chk("lw.adr.srca", 32'(alu_src_a), 2);
      chk("lw.adr.imm",  32'(imm_src), 0);
      for (int i = 0; i < 4; i++) begin
         nxt(i == 3);
         chk("lw.rd.req", 32'(mem_req), 1);
         chk("lw.rd.adr", 32'(adr_src), 1);
      end
      nxt(1'b0);
      chk("lw.wb.rw",  32'(reg_write), 1);
      chk("lw.wb.res", 32'(result_src), 1);
      chk("lw.wb.req", 32'(mem_req), 0);
      nxt(1'b0);
      retire_chk("lw.ret");

      branch("beq.t",  3'b000, 1'b1, 1'b1);
      branch("bne.nt", 3'b001, 1'b1, 1'b0);
      branch("bne.t",  3'b001, 1'b0, 1'b1);

      fd(7'b1101111, 3'b000, 7'h0);
      chk("jal.pcw",  32'(pc_write), 1);
      chk("jal.srca", 32'(alu_src_a), 1);
      chk("jal.srcb", 32'(alu_src_b), 2);
      nxt(1'b0);
      chk("jal.wb", 32'(reg_write), 1);
      nxt(1'b0);
      retire_chk("jal.ret");

      fd(7'b0110111, 3'b000, 7'h0);
      chk("lui.srca", 32'(alu_src_a), 3);
      chk("lui.imm",  32'(imm_src), 4);
      nxt(1'b0);
      chk("lui.wb", 32'(reg_write), 1);
      nxt(1'b0);
      retire_chk("lui.ret");

      // illegal opcode: sticky trap, nothing moves for 100 cycles
      fd(7'b1111111, 3'b000, 7'h0);
      chk("ill.trap",  32'(trap), 1);
      chk("ill.cause", 32'(trap_cause), 1);
      bad = 1'b0;
      for (int i = 0; i < 100; i++) begin
         nxt(1'($urandom_range(1)));
         if (mem_req || pc_write || ir_write || reg_write || mem_we || !trap) bad = 1'b1;
      end
      chk("ill.quiet",   32'(bad), 0);
      chk("ill.cause2",  32'(trap_cause), 1);
      chk("ill.instret", instret, 32'(exp_ret));

      // R-type with funct3=001 is outside the ALU table
      do_rst();
      fd(7'b0110011, 3'b001, 7'h0);
      chk("illf3.cause", 32'(trap_cause), 1);

      // fetch timeout with MEM_TIMEOUT=4
      do_rst();
      chk("tmo.c1", 32'(mem_req), 1);
      nxt(1'b0); nxt(1'b0); nxt(1'b0);
      chk("tmo.c4.req",  32'(mem_req), 1);
      chk("tmo.c4.trap", 32'(trap), 0);
      nxt(1'b0);
      chk("tmo.trap",  32'(trap), 1);
      chk("tmo.cause", 32'(trap_cause), 2);
      chk("tmo.req",   32'(mem_req), 0);
      nxt(1'b1); nxt(1'b1);
      chk("tmo.sticky", 32'(trap_cause), 2);

      // reset in the middle of a stalled store
      do_rst();
      chk("r6.trap", 32'(trap), 0);
      alu_instr("r6.add", 7'b0110011, 3'b000, 7'h00, 3'b000, 2'b00);
      fd(7'b0100011, 3'b010, 7'h0);
      chk("sw.imm", 32'(imm_src), 1);
      nxt(1'b0);
      chk("sw.we",  32'(mem_we), 1);
      chk("sw.adr", 32'(adr_src), 1);
      do_rst();
      chk("r6.req",     32'(mem_req), 1);
      chk("r6.we",      32'(mem_we), 0);
      chk("r6.adr",     32'(adr_src), 0);
      chk("r6.instret", instret, 0);
      chk("r6.trap2",   32'(trap), 0);
      fd(7'b0100011, 3'b010, 7'h0);
      nxt(1'b1);
      chk("sw2.we", 32'(mem_we), 1);
      nxt(1'b0);
      retire_chk("sw2.ret");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
